// File: rtl/pll_reset_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_reset_pkg : shared types and defaults for pll_reset_sequencer   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES        = 2;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_RESET_HOLD_CYCLES  = 16;
    localparam int unsigned DEF_LOSS_CNT_W         = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_bit : STAGES-deep flop chain for one asynchronous input bit    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], din};
        end
    end

    assign dout = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_reset_sequencer : PLL lock flag to clean synchronous sys reset  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int unsigned LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  soft_reset,
    output logic                  sys_reset,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int unsigned c_CNT_W = $clog2(max_u(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)) + 1;
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(RESET_HOLD_CYCLES - 1);

    logic                  w_locked_s;
    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_sys_reset;
    logic                  r_ready;
    logic                  r_lock_lost;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clock (clock),
        .reset (reset),
        .din   (locked),
        .dout  (w_locked_s)
    );

    // Outputs are registered from the next state, so they default to the
    // non-RUN values and only the transitions into/within RUN override them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            case (r_state)
                WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (w_locked_s) begin
                        r_state <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!w_locked_s) begin
                        r_state     <= WAIT_LOCK;
                        r_cnt       <= '0;
                        r_lock_lost <= 1'b1;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_state     <= RUN;
                        r_cnt       <= '0;
                        r_sys_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Lock loss wins over a simultaneous soft reset request.
                    if (!w_locked_s) begin
                        r_state     <= WAIT_LOCK;
                        r_cnt       <= '0;
                        r_lock_lost <= 1'b1;
                        if (r_loss_cnt != {LOSS_CNT_W{1'b1}}) begin
                            r_loss_cnt <= r_loss_cnt + 1'b1;
                        end
                    end else if (soft_reset) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_sys_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_LOCK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign sys_reset       = r_sys_reset;
    assign ready           = r_ready;
    assign lock_lost       = r_lock_lost;
    assign lock_loss_count = r_loss_cnt;

endmodule
`default_nettype wire
